// File: rtl/fib_seq_gen.sv
// fib_seq_gen: sequential Fibonacci generator.
// Accepts an index n on a valid/ready request channel, iterates a/b
// n times, and returns F(n) on a valid/ready response channel.
// rsp_ovf flags that the true F(n) does not fit in WIDTH bits.
// Optional build macro FIB_SAT_EN: saturate rsp_value to all ones on overflow.
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both high. The producer holds valid and its
// payload stable until that edge; ready may be asserted at any time and
// has no effect while valid is low.
module fib_seq_gen #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_idx,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_value,
  output logic             rsp_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  // a holds F(k), b holds F(k+1); ovf_a/ovf_b flag that the true term
  // exceeded WIDTH bits. b runs one term ahead, so only ovf_a reaches
  // the response.
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [IDX_W-1:0] cnt;
  logic             ovf_a;
  logic             ovf_b;
  logic [WIDTH:0]   sum;
  logic             req_fire;
  logic             rsp_fire;
  logic [WIDTH-1:0] result;

  assign sum      = {1'b0, a} + {1'b0, b};
  assign req_fire = req_valid && req_ready;
  assign rsp_fire = rsp_valid && rsp_ready;

`ifdef FIB_SAT_EN
  assign result = ovf_a ? {WIDTH{1'b1}} : a;
`else
  assign result = a;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (rsp_fire) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Iteration datapath and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a         <= '0;
      b         <= '0;
      cnt       <= '0;
      ovf_a     <= 1'b0;
      ovf_b     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_value <= '0;
      rsp_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            cnt   <= req_idx;
            a     <= '0;
            b     <= {{(WIDTH-1){1'b0}}, 1'b1};
            ovf_a <= 1'b0;
            ovf_b <= 1'b0;
          end
        end
        CALC: begin
          if (cnt != '0) begin
            a     <= b;
            b     <= sum[WIDTH-1:0];
            ovf_a <= ovf_b;
            ovf_b <= ovf_a | ovf_b | sum[WIDTH];
            cnt   <= cnt - 1'b1;
          end else begin
            rsp_value <= result;
            rsp_ovf   <= ovf_a;
            rsp_valid <= 1'b1;
          end
        end
        DONE: begin
          if (rsp_fire) begin
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
